// File: rtl/cache_mem_ctrl_pkg.sv
// Shared cache package: controller state encoding and default address/block widths,
// also imported by the cache block itself.
package cache_mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_BLK_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } ctrl_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cache_mem_ctrl_sat_cnt8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_cnt8
  import cache_mem_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= sat_inc8(count);
    end
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Miss-service controller: optional victim write-back, fixed-latency block read
// from external memory, then a held fill handshake back to the cache.
module cache_mem_ctrl
  import cache_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BLK_W  = DEF_BLK_W,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [BLK_W-1:0]  wb_block,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [BLK_W-1:0]  fill_block,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic [BLK_W-1:0]  mem_rdata,
  output logic [7:0]        miss_cnt,
  output logic [7:0]        wb_cnt
);

  ctrl_state_e       state;
  logic [ADDR_W-1:0] req_addr_q;
  logic [2:0]        rd_cnt;
  logic              accept;
  logic              wb_active;

  assign accept    = req_valid && req_ready;
  assign wb_active = (state == WB);

  // The victim address/data are latched straight into the memory-port registers,
  // so the WB cycle drives them directly; the read address is kept for RD and beyond.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      fill_valid <= 1'b0;
      fill_block <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      req_addr_q <= '0;
      rd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_addr_q <= req_addr;
            req_ready  <= 1'b0;
            rd_cnt     <= '0;
            if (req_wb) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= wb_addr;
              mem_wdata <= wb_block;
            end else begin
              state    <= RD;
              mem_addr <= req_addr;
            end
          end
        end
        WB: begin
          state     <= RD;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          mem_addr  <= req_addr_q;
        end
        RD: begin
          // Address has been stable for RD_LAT+1 cycles here, so mem_rdata is valid.
          if (rd_cnt == 3'(RD_LAT)) begin
            fill_block <= mem_rdata;
            fill_valid <= 1'b1;
            state      <= FILL;
          end else begin
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        FILL: begin
          if (fill_ready) begin
            fill_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  sat_cnt8 u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (accept),
    .count (miss_cnt)
  );

  sat_cnt8 u_wb_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (wb_active),
    .count (wb_cnt)
  );

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl with a small external memory model.
module tb_cache_mem_ctrl;

  localparam int RD_LAT = 1;

  typedef struct {
    logic [4:0] data;
    int         lat;
    int         acc;
  } fill_exp_t;

  typedef struct {
    logic [4:0] addr;
    logic [4:0] data;
  } wb_exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_addr = '0;
  logic       req_wb = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [4:0] wb_block = '0;
  logic       fill_valid;
  logic       fill_ready = 1'b1;
  logic [4:0] fill_block;
  logic [4:0] mem_addr;
  logic [4:0] mem_wdata;
  logic       mem_we;
  logic [4:0] mem_rdata;
  logic [7:0] miss_cnt;
  logic [7:0] wb_cnt;

  int total = 0;
  int bad = 0;
  int neg_cyc = 0;
  bit fill_seen = 0;
  fill_exp_t fill_q[$];
  wb_exp_t   wb_q[$];

  logic [4:0] mem [32];
  logic [4:0] rd_pipe [RD_LAT];
  bit mem_init = 0;

  cache_mem_ctrl #(.ADDR_W(5), .BLK_W(5), .RD_LAT(RD_LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wb     (req_wb),
    .wb_addr    (wb_addr),
    .wb_block   (wb_block),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_block (fill_block),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt)
  );

  initial forever #5 clock = ~clock;

  // Memory contents start as mem[i] = i + 9, so mem[0x0A] = 0x13.
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 5'(i + 9);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write cycle and every fill cycle is matched against the queues.
  always @(negedge clock) begin
    neg_cyc++;
    if (!reset) begin
      if (mem_we) begin
        if (wb_q.size() == 0) begin
          check_output("unexpected_write", 1, 0);
        end else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          check_output("wb_addr", int'(mem_addr), int'(w.addr));
          check_output("wb_data", int'(mem_wdata), int'(w.data));
        end
      end
      if (fill_valid) begin
        if (fill_q.size() == 0) begin
          check_output("unexpected_fill", 1, 0);
        end else begin
          check_output("fill_block", int'(fill_block), int'(fill_q[0].data));
          if (!fill_seen) check_output("fill_latency", neg_cyc - fill_q[0].acc, fill_q[0].lat);
          fill_seen = 1;
          if (fill_ready) begin
            void'(fill_q.pop_front());
            fill_seen = 0;
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [4:0] a, input logic w, input logic [4:0] wa,
                                input logic [4:0] wd, input logic [4:0] exp_data);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) check_output("req_ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_wb    = w;
    wb_addr   = wa;
    wb_block  = wd;
    @(posedge clock);
    #1;
    fill_q.push_back('{exp_data, w ? RD_LAT + 3 : RD_LAT + 2, neg_cyc});
    if (w) wb_q.push_back('{wa, wd});
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wb    = ~w;
    wb_addr   = ~wa;
    wb_block  = ~wd;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((fill_q.size() != 0 || !req_ready) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check_output("drain_timeout", guard < 100 ? 1 : 0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] held;
    int guard;
    repeat (3) @(negedge clock);
    check_output("rst_req_ready", int'(req_ready), 1);
    check_output("rst_fill_valid", int'(fill_valid), 0);
    check_output("rst_fill_block", int'(fill_block), 0);
    check_output("rst_mem_we", int'(mem_we), 0);
    check_output("rst_mem_addr", int'(mem_addr), 0);
    check_output("rst_mem_wdata", int'(mem_wdata), 0);
    check_output("rst_miss_cnt", int'(miss_cnt), 0);
    check_output("rst_wb_cnt", int'(wb_cnt), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    $display("[TB] clean miss");
    apply_stimulus(5'h0A, 1'b0, 5'h00, 5'h00, 5'h13);
    wait_drain();
    check_output("clean_miss_cnt", int'(miss_cnt), 1);
    check_output("clean_wb_cnt", int'(wb_cnt), 0);

    $display("[TB] dirty miss");
    apply_stimulus(5'h04, 1'b1, 5'h06, 5'h1F, 5'h0D);
    wait_drain();
    check_output("dirty_mem6", int'(mem[6]), 'h1F);
    check_output("dirty_miss_cnt", int'(miss_cnt), 2);
    check_output("dirty_wb_cnt", int'(wb_cnt), 1);

    $display("[TB] same-address write-back");
    apply_stimulus(5'h02, 1'b1, 5'h02, 5'h15, 5'h15);
    wait_drain();
    check_output("same_wb_cnt", int'(wb_cnt), 2);

    $display("[TB] backpressure");
    apply_stimulus(5'h0A, 1'b0, 5'h00, 5'h00, 5'h13);
    fill_ready = 1'b0;
    guard = 0;
    @(negedge clock);
    while (!fill_valid && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check_output("bp_fill_arrived", int'(fill_valid), 1);
    held = fill_block;
    for (int k = 0; k < 5; k++) begin
      check_output("bp_fill_valid", int'(fill_valid), 1);
      check_output("bp_fill_stable", int'(fill_block), int'(held));
      check_output("bp_req_ready", int'(req_ready), 0);
      @(posedge clock);
      #1;
    end
    fill_ready = 1'b1;
    @(negedge clock);
    check_output("bp_last_valid", int'(fill_valid), 1);
    @(negedge clock);
    check_output("bp_idle_ready", int'(req_ready), 1);
    check_output("bp_idle_valid", int'(fill_valid), 0);
    check_output("bp_miss_cnt", int'(miss_cnt), 4);

    $display("[TB] reset during write-back");
    apply_stimulus(5'h08, 1'b1, 5'h09, 5'h01, 5'h11);
    check_output("wbrst_we_before", int'(mem_we), 1);
    #1 reset = 1'b1;
    #1;
    check_output("wbrst_we_async", int'(mem_we), 0);
    check_output("wbrst_req_ready", int'(req_ready), 1);
    check_output("wbrst_miss_cnt", int'(miss_cnt), 0);
    fill_q.delete();
    wb_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_output("wbrst_ready_after", int'(req_ready), 1);
    repeat (8) @(negedge clock);
    check_output("wbrst_no_fill", int'(fill_valid), 0);
    check_output("wbrst_mem9_kept", int'(mem[9]), 'h12);

    $display("[TB] 300 back-to-back clean misses");
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(5'(16 + k % 16), 1'b0, 5'h00, 5'h00, 5'(16 + k % 16 + 9));
    end
    wait_drain();
    check_output("sat_miss_cnt", int'(miss_cnt), 255);
    check_output("sat_wb_cnt", int'(wb_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_ctrl.md
CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, memory word address width.
REQ-002 Parameter BLK_W, default 5, block data width.
REQ-003 Parameter RD_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  cache requests a miss service.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_addr  in  ADDR_W  address of the missing block.
REQ-009 req_wb  in  1  dirty victim must be written back first.
REQ-010 wb_addr  in  ADDR_W  victim address.
REQ-011 wb_block  in  BLK_W  victim data.
REQ-012 fill_valid  out  1  fill data available to the cache.
REQ-013 fill_ready  in  1  cache consumes fill data.
REQ-014 fill_block  out  BLK_W  block read from memory.
REQ-015 mem_addr  out  ADDR_W  memory address.
REQ-016 mem_wdata  out  BLK_W  memory write data.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_rdata  in  BLK_W  memory read data.
REQ-019 miss_cnt  out  8  count of accepted requests; saturates at 255.
REQ-020 wb_cnt  out  8  count of write-backs performed; saturates at 255.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, WB, RD, FILL.
REQ-022 req_ready SHALL be 1 only in IDLE.
REQ-023 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; req_addr, req_wb, wb_addr and wb_block are then latched.
REQ-024 On accept, the next state SHALL be WB if req_wb=1, else RD.
REQ-025 WB SHALL last exactly 1 cycle, driving mem_we=1, mem_addr=latched wb_addr and mem_wdata=latched wb_block, then go to RD.
REQ-026 RD SHALL last RD_LAT+1 cycles with mem_we=0 and mem_addr=latched req_addr held stable.
REQ-027 mem_rdata SHALL be captured into fill_block on the edge ending the last RD cycle, and the next state SHALL be FILL.
REQ-028 In FILL, fill_valid SHALL be 1, and fill_block SHALL be held stable until an edge with fill_ready=1; the next state is then IDLE.
REQ-029 fill_valid SHALL be 0 in every state other than FILL; fill_ready SHALL be ignored outside FILL.
REQ-030 A new request SHALL NOT be accepted in the same cycle that FILL completes; IDLE lasts at least 1 cycle.
REQ-031 Outside WB: mem_we SHALL be 0, mem_wdata SHALL be 0, and mem_addr SHALL be the latched req_addr.
REQ-032 If wb_addr equals req_addr, the write SHALL still precede the read, so the fill returns wb_block.
REQ-033 miss_cnt SHALL increment on each accept; wb_cnt SHALL increment on each WB cycle; both hold at 255.
REQ-034 Latency from the accept edge to the first fill_valid=1 cycle: RD_LAT+2 cycles without write-back, RD_LAT+3 with write-back.
REQ-035 Input changes after accept SHALL NOT affect the operation in progress.

Reset
REQ-036 On reset the controller SHALL enter IDLE immediately, asynchronously, including from any state mid-operation.
REQ-037 Reset values: req_ready=1, fill_valid=0, fill_block=0, mem_we=0, mem_addr=0, mem_wdata=0, miss_cnt=0, wb_cnt=0.
REQ-038 An aborted write-back or fill SHALL NOT be resumed after reset is released.

Structure
REQ-039 The state encoding and the ADDR_W/BLK_W defaults SHALL live in a shared cache package, also used by the cache block.
REQ-040 The saturating 8-bit counter SHALL be one sub-module, sat_cnt8, instantiated twice.
REQ-041 The memory itself SHALL be external to this block.

Verification
REQ-042 Clean miss, RD_LAT=1: req_addr=5'h0A, req_wb=0, memory[0x0A]=5'h13 -> fill_valid=1 with fill_block=5'h13 exactly 3 cycles after accept; mem_we never 1; miss_cnt=1.
REQ-043 Dirty miss: req_addr=5'h04, req_wb=1, wb_addr=5'h06, wb_block=5'h1F -> one cycle with mem_we=1, mem_addr=5'h06, mem_wdata=5'h1F; memory[0x06]=5'h1F afterwards; fill 4 cycles after accept; wb_cnt=1.
REQ-044 Same-address write-back: req_addr=wb_addr=5'h02, wb_block=5'h15 -> fill_block=5'h15.
REQ-045 Backpressure: fill_ready held 0 for 5 cycles in FILL -> fill_valid and fill_block stable throughout; req_ready=0 throughout; IDLE is reached 1 cycle after fill_ready=1.
REQ-046 Reset asserted during WB -> mem_we drops to 0 without waiting for a clock edge; after release, req_ready=1 and no fill is produced.
REQ-047 300 back-to-back clean misses -> miss_cnt=255, wb_cnt=0.
